// File: rtl/gdiv_sequencer.sv
// Handshaked sequencing controller for the shared-multiplier Goldschmidt
// mantissa divider: seed, refinement iterations, remainder sign, held result.
module gdiv_sequencer #(
  parameter int unsigned ITERS = 3,
  parameter int unsigned CNT_W = $clog2(ITERS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             round_mode_in,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             round_mode,
  output logic [1:0]       sA,
  output logic [1:0]       sB,
  output logic             enableN,
  output logic             enableD,
  output logic             enableK,
  output logic             enableQD,
  output logic             busy,
  output logic [CNT_W-1:0] iter
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    N0   = 3'd1,
    D0   = 3'd2,
    NI   = 3'd3,
    DI   = 3'd4,
    REM  = 3'd5,
    DONE = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             round_mode_q, round_mode_d;
  logic             in_flight;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      iter_q       <= '0;
      round_mode_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      iter_q       <= iter_d;
      round_mode_q <= round_mode_d;
    end
  end

  assign in_flight = (state_q != IDLE) && (state_q != DONE);

  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    round_mode_d = round_mode_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d      = N0;
          iter_d       = '0;
          round_mode_d = round_mode_in;
        end
      end
      N0:  state_d = D0;
      D0: begin
        state_d = NI;
        iter_d  = CNT_W'(1);
      end
      NI:  state_d = (iter_q == CNT_W'(ITERS)) ? REM : DI;
      DI: begin
        state_d = NI;
        iter_d  = iter_q + CNT_W'(1);
      end
      REM: state_d = DONE;
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            state_d      = N0;
            iter_d       = '0;
            round_mode_d = round_mode_in;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        iter_d  = '0;
      end
    endcase
    // abort only flushes in-flight work; IDLE/DONE decisions above stand
    if (abort && in_flight) begin
      state_d = IDLE;
      iter_d  = '0;
    end
  end

  // Control decode is gated by reset so nothing leaks before the first edge.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sA        = 2'b00;
    sB        = 2'b00;
    enableN   = 1'b0;
    enableD   = 1'b0;
    enableK   = 1'b0;
    enableQD  = 1'b0;
    busy      = 1'b0;
    if (!reset) begin
      busy = in_flight;
      unique case (state_q)
        IDLE: in_ready = 1'b1;
        N0: begin
          sA      = 2'b00;
          sB      = 2'b00;
          enableN = 1'b1;
        end
        D0: begin
          sA      = 2'b01;
          sB      = 2'b00;
          enableD = 1'b1;
          enableK = 1'b1;
        end
        NI: begin
          sA      = 2'b10;
          sB      = 2'b01;
          enableN = 1'b1;
        end
        DI: begin
          sA      = 2'b11;
          sB      = 2'b01;
          enableD = 1'b1;
          enableK = 1'b1;
        end
        REM: begin
          sA       = 2'b10;
          sB       = 2'b10;
          enableQD = 1'b1;
        end
        DONE: begin
          out_valid = 1'b1;
          in_ready  = out_ready;
        end
        default: ;
      endcase
    end
  end

  assign iter       = iter_q;
  assign round_mode = round_mode_q;

endmodule

// File: tb/tb_gdiv_sequencer.sv
// Randomized bench for gdiv_sequencer (ITERS=3 and ITERS=1 instances) against
// a cycle-count transaction model: phase k after accept fixes every output.
module tb_gdiv_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic in_valid = 1'b0, round_mode_in = 1'b0, abort = 1'b0, out_ready = 1'b0;

  logic       in_ready3, out_valid3, rm3, enN3, enD3, enK3, enQD3, busy3;
  logic [1:0] sA3, sB3, it3;
  logic       in_ready1, out_valid1, rm1, enN1, enD1, enK1, enQD1, busy1;
  logic [1:0] sA1, sB1;
  logic [0:0] it1;

  gdiv_sequencer #(.ITERS(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3),
    .round_mode_in(round_mode_in), .abort(abort), .out_valid(out_valid3),
    .out_ready(out_ready), .round_mode(rm3), .sA(sA3), .sB(sB3),
    .enableN(enN3), .enableD(enD3), .enableK(enK3), .enableQD(enQD3),
    .busy(busy3), .iter(it3)
  );

  gdiv_sequencer #(.ITERS(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .round_mode_in(round_mode_in), .abort(abort), .out_valid(out_valid1),
    .out_ready(out_ready), .round_mode(rm1), .sA(sA1), .sB(sB1),
    .enableN(enN1), .enableD(enD1), .enableK(enK1), .enableQD(enQD1),
    .busy(busy1), .iter(it1)
  );

  // {in_ready, out_valid, sA, sB, enN, enD, enK, enQD, busy}
  logic [10:0] ctl_obs [2];
  logic [3:0]  iter_obs [2];
  logic        rm_obs [2];
  assign ctl_obs[0]  = {in_ready3, out_valid3, sA3, sB3, enN3, enD3, enK3, enQD3, busy3};
  assign ctl_obs[1]  = {in_ready1, out_valid1, sA1, sB1, enN1, enD1, enK1, enQD1, busy1};
  assign iter_obs[0] = {2'b00, it3};
  assign iter_obs[1] = {3'b000, it1};
  assign rm_obs[0]   = rm3;
  assign rm_obs[1]   = rm1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Model: mode 0=idle, 1=in flight (k cycles since accept), 2=result held.
  int unsigned m_mode [2];
  int unsigned m_k    [2];
  int unsigned m_iter [2];
  logic        m_rm   [2];
  bit          known = 1'b0;
  int unsigned completions = 0;

  function automatic int unsigned iters_of(input int unsigned n);
    return (n == 0) ? 3 : 1;
  endfunction

  function automatic logic [10:0] exp_ctl(input int unsigned n);
    logic ir, ov, en_n, en_d, en_k, en_qd, bsy;
    logic [1:0] a, b;
    int unsigned last;
    ir = 0; ov = 0; a = 0; b = 0; en_n = 0; en_d = 0; en_k = 0; en_qd = 0; bsy = 0;
    last = 2 * iters_of(n) + 1;
    if (!reset) begin
      if (m_mode[n] == 0) ir = 1;
      else if (m_mode[n] == 2) begin
        ov = 1;
        ir = out_ready;
      end else begin
        bsy = 1;
        if (m_k[n] == 0) begin a = 0; b = 0; en_n = 1; end
        else if (m_k[n] == 1) begin a = 1; b = 0; en_d = 1; en_k = 1; end
        else if (m_k[n] == last) begin a = 2; b = 2; en_qd = 1; end
        else if (m_k[n] % 2 == 0) begin a = 2; b = 1; en_n = 1; end
        else begin a = 3; b = 1; en_d = 1; en_k = 1; end
      end
    end
    return {ir, ov, a, b, en_n, en_d, en_k, en_qd, bsy};
  endfunction

  task automatic model_step(input int unsigned n);
    int unsigned last;
    last = 2 * iters_of(n) + 1;
    if (reset) begin
      m_mode[n] = 0; m_k[n] = 0; m_iter[n] = 0; m_rm[n] = 0;
    end else if (m_mode[n] == 0) begin
      if (in_valid) begin
        m_mode[n] = 1; m_k[n] = 0; m_iter[n] = 0; m_rm[n] = round_mode_in;
      end
    end else if (m_mode[n] == 1) begin
      if (abort) begin
        m_mode[n] = 0; m_iter[n] = 0;
      end else if (m_k[n] == last) begin
        m_mode[n] = 2; m_iter[n] = iters_of(n);
      end else begin
        m_k[n]++;
        m_iter[n] = m_k[n] / 2;
      end
    end else if (out_ready) begin
      if (n == 0) completions++;
      if (in_valid) begin
        m_mode[n] = 1; m_k[n] = 0; m_iter[n] = 0; m_rm[n] = round_mode_in;
      end else m_mode[n] = 0;
    end
  endtask

  task automatic run_cycles(input int unsigned cycles, input int unsigned p_iv,
                            input int unsigned p_ordy, input int unsigned p_ab,
                            input int unsigned pm_rst);
    for (int unsigned c = 0; c < cycles; c++) begin
      @(negedge clk);
      reset         = ($urandom_range(999) < pm_rst);
      in_valid      = ($urandom_range(99) < p_iv);
      round_mode_in = $urandom_range(1);
      abort         = ($urandom_range(99) < p_ab);
      out_ready     = ($urandom_range(99) < p_ordy);
      #1;
      for (int unsigned n = 0; n < 2; n++) begin
        check(n == 0 ? "ctl_it3" : "ctl_it1", {5'b0, ctl_obs[n]}, {5'b0, exp_ctl(n)});
        if (known) begin
          check(n == 0 ? "iter_it3" : "iter_it1", {12'b0, iter_obs[n]}, 16'(m_iter[n]));
          check(n == 0 ? "rm_it3" : "rm_it1", {15'b0, rm_obs[n]}, {15'b0, m_rm[n]});
        end
      end
      @(posedge clk);
      model_step(0);
      model_step(1);
      if (reset) known = 1'b1;
    end
  endtask

  initial begin
    for (int unsigned n = 0; n < 2; n++) begin
      m_mode[n] = 0; m_k[n] = 0; m_iter[n] = 0; m_rm[n] = 0;
    end
    run_cycles(3, 0, 0, 0, 1000);     // reset held
    run_cycles(400, 30, 70, 0, 0);    // sparse requests, no abort
    run_cycles(300, 100, 100, 0, 0);  // back-to-back with toggling mode
    run_cycles(300, 50, 10, 0, 0);    // consumer stalls in DONE
    run_cycles(600, 60, 60, 8, 0);    // aborts mixed in
    run_cycles(600, 70, 50, 4, 15);   // occasional mid-flight reset
    run_cycles(200, 40, 80, 50, 0);   // heavy abort incl. abort in IDLE
    n_checks++;
    if (completions < 20) begin
      n_errors++;
      $display("FAIL completions: got %0d expected at least 20", completions);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
